// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: handshake, occupancy and clear
// sequencing for the 8x9 FIFO storage block.
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic        wren,
  output logic        wrinc,
  output logic        rden,
  output logic        rdinc,
  output logic        wrptr_clr,
  output logic        rdptr_clr,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        ovld_q, ovld_d;

  logic run;
  logic wr_ev;
  logic rd_ev;

  // Handshake strobes and next state.
  always_comb begin
    run     = (state_q == S_RUN);
    state_d = state_q;
    count_d = count_q;
    ovld_d  = ovld_q;

    in_ready = run && !full_q && !flush;
    wr_ev    = in_valid && in_ready;
    rd_ev    = run && !empty_q && !flush &&
               (!ovld_q || out_ready);

    unique case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN:   state_d = flush ? S_FLUSH : S_RUN;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_INIT;
    endcase

    // A flush discards the word on DataOut too.
    if (!run || flush) begin
      count_d = '0;
      ovld_d  = 1'b0;
    end else begin
      unique case ({wr_ev, rd_ev})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      if (rd_ev) begin
        ovld_d = 1'b1;
      end else if (ovld_q && out_ready) begin
        ovld_d = 1'b0;
      end
    end

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // State, occupancy and output-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovld_q  <= ovld_d;
    end
  end

  assign wren      = wr_ev;
  assign wrinc     = wr_ev;
  assign rden      = rd_ev;
  assign rdinc     = rd_ev;
  assign wrptr_clr = !run;
  assign rdptr_clr = !run;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign out_valid = ovld_q;

endmodule
